// File: rtl/instr_fetch_unit.sv
// Purpose : sequential instruction fetch with a 2-entry decode buffer and branch redirect.
// Latency : request issued the cycle after the decision; ack data is visible on instr the cycle after ack.
// Backpres: new fetches stop while the buffer has no room; instr/instr_pc hold while instr_ready is low.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   imem_req/imem_addr                single-outstanding fetch request, held until imem_ack
//   imem_ack/imem_rdata               one-cycle response strobe and returned word
//   instr_valid/instr/instr_pc        buffer head toward decode (NOP_INSTR / 0 when empty)
//   instr_ready                       decode accepts head
//   redirect_valid/redirect_pc        taken branch/jump, flushes buffer and retargets the PC
//   misalign_err                      one-cycle pulse after a redirect with redirect_pc[1:0] != 0

// Purpose : generic valid/ready FIFO with synchronous flush.
// Latency : a word pushed at edge N is presented on out_dat after edge N.
// Backpres: push is dropped when full unless a pop happens in the same cycle.
module ifu_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push_vld,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop_rdy,
  output logic                       out_vld,
  output logic [W-1:0]               out_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rptr, wptr;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign out_vld = (count != '0);
  assign out_dat = mem[rptr];
  assign do_pop  = pop_rdy && out_vld && !flush;
  // Pushing into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push = push_vld && !flush && ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= ptr_inc(wptr);
      if (do_pop)  rptr <= ptr_inc(rptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_dat;
  end
endmodule

module instr_fetch_unit #(
  parameter int          XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            misalign_err
);
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t            state, state_nxt;
  logic [XLEN-1:0]   pc, pc_nxt, addr_nxt;
  logic              req_nxt;
  logic              push;
  logic              space;
  logic              head_vld;
  logic [XLEN+31:0]  head_dat;
  logic [1:0]        fifo_cnt;

  // Room exists if the buffer is not full or the head leaves this cycle.
  assign space = (fifo_cnt != 2'd2) || (head_vld && instr_ready);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    req_nxt   = imem_req;
    addr_nxt  = imem_addr;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (!redirect_valid && space) begin
          req_nxt   = 1'b1;
          addr_nxt  = pc;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          req_nxt   = 1'b0;
          state_nxt = IDLE;
          // Data returning alongside a redirect is stale: drop it, keep the new PC.
          if (!redirect_valid) begin
            push   = 1'b1;
            pc_nxt = pc + XLEN'(4);
          end
        end else if (redirect_valid) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (imem_ack) begin
          req_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (redirect_valid) pc_nxt = {redirect_pc[XLEN-1:2], 2'b00};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      imem_req     <= 1'b0;
      imem_addr    <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      imem_req     <= req_nxt;
      imem_addr    <= addr_nxt;
      misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
    end
  end

  ifu_fifo #(.W(XLEN+32), .DEPTH(2)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_valid),
    .push_vld (push),
    .push_dat ({imem_rdata, imem_addr}),
    .pop_rdy  (instr_ready),
    .out_vld  (head_vld),
    .out_dat  (head_dat),
    .count    (fifo_cnt)
  );

  assign instr_valid = head_vld;
  assign instr       = head_vld ? head_dat[XLEN+31:XLEN] : NOP_INSTR;
  assign instr_pc    = head_vld ? head_dat[XLEN-1:0] : '0;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Purpose : directed bench for instr_fetch_unit with a scripted instruction-memory responder.
// Latency : memory acks after a programmable number of cycles of imem_req.
// Backpres: instr_ready driven per scenario.
module tb_instr_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        misalign_err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int mem_lat = 1;
  int wait_cnt = 0;
  bit req_prev = 1'b0;
  logic [31:0] req_log[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_word[$];
  int          pop_cyc[$];

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {12'hABC, a[19:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Memory model: logs each new request, acks after mem_lat cycles of imem_req.
  task automatic mem_step();
    imem_ack = 1'b0;
    if (imem_req) begin
      if (!req_prev) begin
        req_log.push_back(imem_addr);
        wait_cnt = 0;
      end
      wait_cnt++;
      if (wait_cnt >= mem_lat) begin
        imem_ack   = 1'b1;
        imem_rdata = word_of(imem_addr);
        wait_cnt   = 0;
      end
    end
    req_prev = imem_req;
  endtask

  // One clock: record any pop the coming edge performs, then sample/drive at posedge+1.
  task automatic tick();
    if (rst_n && instr_valid && instr_ready && !redirect_valid) begin
      pop_pc.push_back(instr_pc);
      pop_word.push_back(instr);
      pop_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    mem_step();
  endtask

  task automatic clear_logs();
    req_log.delete();
    pop_pc.delete();
    pop_word.delete();
    pop_cyc.delete();
    wait_cnt = 0;
    req_prev = 1'b0;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    tick();
    tick();
    clear_logs();
    rst_n = 1'b1;
  endtask

  task automatic wait_pops(input int n, input string tag);
    for (int i = 0; i < 300 && pop_pc.size() < n; i++) tick();
    check(tag, pop_pc.size(), n);
  endtask

  task automatic wait_req(input logic [31:0] addr, input bit need_ack, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      tick();
      hit = imem_req && (imem_addr == addr) && (!need_ack || imem_ack);
    end
    check(tag, {31'b0, hit}, 32'd1);
  endtask

  task automatic pulse_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    // Reset values
    rst_n = 1'b0;
    tick();
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, NOP);
    check("rst_pc", instr_pc, 32'h0);
    check("rst_misalign", misalign_err, 0);

    // Streaming with 1-cycle ack and decode always ready
    mem_lat     = 1;
    instr_ready = 1'b1;
    do_reset();
    wait_pops(3, "run_pops");
    for (int i = 0; i < 3; i++) begin
      check($sformatf("run_req%0d", i), req_log[i], 32'(4 * i));
      check($sformatf("run_pc%0d", i), pop_pc[i], 32'(4 * i));
      check($sformatf("run_word%0d", i), pop_word[i], word_of(32'(4 * i)));
    end
    check("run_gap1", 32'(pop_cyc[1] - pop_cyc[0]), 32'd2);
    check("run_gap2", 32'(pop_cyc[2] - pop_cyc[1]), 32'd2);

    // Backpressure: buffer fills with two words, then drains in order
    instr_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    check("full_nreq", req_log.size(), 2);
    check("full_req_low", imem_req, 0);
    check("full_valid", instr_valid, 1);
    check("full_head_pc", instr_pc, 32'h0);
    check("full_head_word", instr, word_of(32'h0));
    instr_ready = 1'b1;
    wait_pops(3, "drain_pops");
    check("drain_pc0", pop_pc[0], 32'h0);
    check("drain_pc1", pop_pc[1], 32'h4);
    check("drain_pc2", pop_pc[2], 32'h8);
    check("drain_req2", req_log[2], 32'h8);

    // Redirect while the fetch of 0x8 is outstanding (3-cycle ack)
    mem_lat     = 3;
    instr_ready = 1'b1;
    do_reset();
    wait_req(32'h8, 1'b0, "drop_req8");
    pulse_redirect(32'h100);
    check("drop_empty", instr_valid, 0);
    check("drop_hold_req", imem_req, 1);
    check("drop_hold_addr", imem_addr, 32'h8);
    check("drop_misalign", misalign_err, 0);
    wait_pops(3, "drop_pops");
    check("drop_pc1", pop_pc[1], 32'h4);
    check("drop_pc2", pop_pc[2], 32'h100);
    check("drop_word2", pop_word[2], word_of(32'h100));
    check("drop_req3", req_log[3], 32'h100);

    // Redirect coinciding with the ack for 0xC
    mem_lat = 1;
    do_reset();
    wait_req(32'hC, 1'b1, "coack_reqC");
    pulse_redirect(32'h40);
    check("coack_req_low", imem_req, 0);
    check("coack_valid", instr_valid, 0);
    wait_pops(4, "coack_pops");
    check("coack_pc3", pop_pc[3], 32'h40);
    check("coack_word3", pop_word[3], word_of(32'h40));
    check("coack_req4", req_log[4], 32'h40);

    // Misaligned redirect with a full buffer
    instr_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    check("mis_full_valid", instr_valid, 1);
    pulse_redirect(32'h203);
    check("mis_pulse", misalign_err, 1);
    check("mis_flush", instr_valid, 0);
    tick();
    check("mis_pulse_end", misalign_err, 0);
    instr_ready = 1'b1;
    wait_pops(1, "mis_pops");
    check("mis_pc0", pop_pc[0], 32'h200);
    check("mis_req2", req_log[2], 32'h200);

    // Asynchronous reset while waiting on a slow fetch, then a stale ack
    instr_ready = 1'b0;
    mem_lat     = 1;
    do_reset();
    for (int i = 0; i < 50 && !instr_valid; i++) tick();
    check("ar_buffered", instr_valid, 1);
    mem_lat = 50;
    wait_req(32'h4, 1'b0, "ar_req4");
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_req", imem_req, 0);
    check("ar_addr", imem_addr, 32'h0);
    check("ar_valid", instr_valid, 0);
    check("ar_instr", instr, NOP);
    check("ar_pc", instr_pc, 32'h0);
    tick();
    clear_logs();
    mem_lat    = 1;
    rst_n      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    check("ar_stale_valid", instr_valid, 0);
    check("ar_first_req", req_log[0], 32'h0);
    instr_ready = 1'b1;
    wait_pops(1, "ar_pops");
    check("ar_word0", pop_word[0], word_of(32'h0));
    check("ar_pc0", pop_pc[0], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
